// File: rtl/stream_loaded_ram_if.sv
// Handshake bundle for stream_loaded_ram: clear control, write stream and read port.
// Ports:
//   master - driven by the tile I/O side (stream source, read requester)
//   slave  - the memory block itself
interface stream_loaded_ram_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              clr_start;
    logic              busy;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              wr_rewind;
    logic [ADDR_W:0]   wr_ptr;
    logic              wr_full;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_seq;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output clr_start, wr_valid, wr_data, wr_rewind, rd_en, rd_addr, rd_seq,
        input  busy, wr_ready, wr_ptr, wr_full, rd_data, rd_valid
    );

    modport slave (
        input  clr_start, wr_valid, wr_data, wr_rewind, rd_en, rd_addr, rd_seq,
        output busy, wr_ready, wr_ptr, wr_full, rd_data, rd_valid
    );
endinterface

// File: rtl/stream_loaded_ram.sv
// DEPTH x DATA_W memory loaded through a valid/ready write stream with an
// auto-incrementing write pointer and read through a registered port
// (1-cycle latency, read-before-write). Contents are zeroed by a hardware
// sweep of DEPTH cycles after reset and on clr_start.
// Ports:
//   clk_i-style plain ports: clk (rising edge), rst (async, active-high)
//   bus : stream_loaded_ram_if.slave (clear, write stream, read port)
// Optional feature macro: RD_SEQ_EN - adds an internal sequential read
// pointer selected by rd_seq that replays only the loaded words.
//
// state | meaning
// CLEAR | sweeping zeros through memory, busy=1, reads/writes dropped
// IDLE  | normal operation, stream writes and reads accepted
module stream_loaded_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                clk,
    input  logic                rst,
    stream_loaded_ram_if.slave  bus
);
    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_P = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, IDLE} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [IDX_W-1:0]    mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [ADDR_W:0]     rd_idx;
    logic                rd_zero;
    logic                busy;
    logic                wr_full;
    logic                wr_ready;

`ifdef RD_SEQ_EN
    logic [ADDR_W:0]     rd_ptr_q, rd_ptr_d;
`else
    logic                unused_rd_seq;
    assign unused_rd_seq = bus.rd_seq;
`endif

    assign busy     = (state_q == CLEAR);
    assign wr_full  = (wr_ptr_q == DEPTH_P);
    assign wr_ready = !busy && !wr_full;

    assign bus.busy     = busy;
    assign bus.wr_full  = wr_full;
    assign bus.wr_ready = wr_ready;
    assign bus.wr_ptr   = wr_ptr_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        rd_idx     = {1'b0, bus.rd_addr};
        rd_zero    = 1'b0;
`ifdef RD_SEQ_EN
        rd_ptr_d   = rd_ptr_q;
`endif
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q[IDX_W-1:0];
                if (clr_cnt_q == LAST_P) begin
                    state_d = IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: begin
                if (bus.rd_en) begin
`ifdef RD_SEQ_EN
                    if (bus.rd_seq) begin
                        rd_idx = rd_ptr_q;
                        // Nothing loaded yet: answer zero and keep the pointer parked.
                        if (wr_ptr_q == '0) begin
                            rd_zero = 1'b1;
                        end else if (rd_ptr_q + 1'b1 == wr_ptr_q) begin
                            rd_ptr_d = '0;
                        end else begin
                            rd_ptr_d = rd_ptr_q + 1'b1;
                        end
                    end
`endif
                    rd_valid_d = 1'b1;
                    rd_data_d  = (rd_zero || rd_idx >= DEPTH_P) ? '0
                                                                : mem_q[rd_idx[IDX_W-1:0]];
                end
                // Clear and rewind both win over a simultaneous stream transfer.
                if (bus.clr_start) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                    wr_ptr_d  = '0;
`ifdef RD_SEQ_EN
                    rd_ptr_d  = '0;
`endif
                end else if (bus.wr_rewind) begin
                    wr_ptr_d  = '0;
`ifdef RD_SEQ_EN
                    rd_ptr_d  = '0;
`endif
                end else if (bus.wr_valid && wr_ready) begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_ptr_q[IDX_W-1:0];
                    mem_wdata = bus.wr_data;
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                end
            end
        endcase
    end

    // Memory has no reset; the CLEAR sweep provides its initial contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
`ifdef RD_SEQ_EN
            rd_ptr_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
`ifdef RD_SEQ_EN
            rd_ptr_q   <= rd_ptr_d;
`endif
        end
    end
endmodule

// File: tb/tb_stream_loaded_ram.sv
module tb_stream_loaded_ram;
    logic clk;
    logic rst;

    stream_loaded_ram_if #(.DATA_W(8), .ADDR_W(8)) bus_if ();

    stream_loaded_ram #(.DATA_W(8), .ADDR_W(8), .DEPTH(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];
    logic [7:0] model [256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    // Scoreboard: every rd_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && bus_if.rd_valid) begin
            n_assert++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL rd_unexpected observed rd_valid=1 required no read result");
            end
            if (exp_q.size() != 0) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                n_assert++;
                assert (bus_if.rd_data === e) else begin
                    n_fail++;
                    $error("FAIL sb_rd_data observed=%0h expected=%0h", bus_if.rd_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd1(input string tag, input logic [7:0] addr);
        exp_q.push_back(model[addr]);
        bus_if.rd_en   = 1'b1;
        bus_if.rd_addr = addr;
        tick();
        bus_if.rd_en = 1'b0;
        check({tag, "_valid"}, {31'd0, bus_if.rd_valid}, 32'd1);
        check({tag, "_data"}, {24'd0, bus_if.rd_data}, {24'd0, model[addr]});
    endtask

    task automatic drain();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        check("sb_drain", exp_q.size(), 0);
    endtask

    task automatic count_busy(input string tag);
        int cyc;
        cyc = 0;
        while (bus_if.busy && cyc < 1000) begin
            check({tag, "_wr_ready"}, {31'd0, bus_if.wr_ready}, 32'd0);
            tick();
            cyc++;
        end
        check({tag, "_cycles"}, cyc, 256);
    endtask

    initial begin
        logic [7:0] seq_exp [5];
        logic [7:0] seq_addr [5];
        rst = 1'b1;
        bus_if.clr_start = 1'b0;
        bus_if.wr_valid  = 1'b0;
        bus_if.wr_data   = '0;
        bus_if.wr_rewind = 1'b0;
        bus_if.rd_en     = 1'b0;
        bus_if.rd_addr   = '0;
        bus_if.rd_seq    = 1'b0;
        for (int i = 0; i < 256; i++) model[i] = 8'h00;

        // 1: reset values, sweep length, cleared memory
        tick();
        tick();
        check("rst_busy", {31'd0, bus_if.busy}, 32'd1);
        check("rst_wr_ready", {31'd0, bus_if.wr_ready}, 32'd0);
        check("rst_wr_ptr", {23'd0, bus_if.wr_ptr}, 32'd0);
        check("rst_wr_full", {31'd0, bus_if.wr_full}, 32'd0);
        check("rst_rd_valid", {31'd0, bus_if.rd_valid}, 32'd0);
        check("rst_rd_data", {24'd0, bus_if.rd_data}, 32'd0);
        rst = 1'b0;
        count_busy("sweep0");
        check("idle_wr_ready", {31'd0, bus_if.wr_ready}, 32'd1);
        rd1("rd0", 8'd0);
        rd1("rd100", 8'd100);
        rd1("rd255", 8'd255);

        // 2: short stream, single read latency
        bus_if.wr_valid = 1'b1;
        bus_if.wr_data = 8'h11; model[0] = 8'h11; tick();
        bus_if.wr_data = 8'h22; model[1] = 8'h22; tick();
        bus_if.wr_data = 8'h33; model[2] = 8'h33; tick();
        bus_if.wr_valid = 1'b0;
        check("wr_ptr3", {23'd0, bus_if.wr_ptr}, 32'd3);
        rd1("rd_a1", 8'd1);

        // 3: fill to full, overflow stall, rewind priority
        bus_if.wr_rewind = 1'b1; tick(); bus_if.wr_rewind = 1'b0;
        check("rewind_ptr", {23'd0, bus_if.wr_ptr}, 32'd0);
        bus_if.wr_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus_if.wr_data = 8'(i);
            model[i] = 8'(i);
            tick();
        end
        check("full_ptr", {23'd0, bus_if.wr_ptr}, 32'd256);
        check("full_flag", {31'd0, bus_if.wr_full}, 32'd1);
        check("full_ready", {31'd0, bus_if.wr_ready}, 32'd0);
        bus_if.wr_data = 8'hEE; tick();
        bus_if.wr_valid = 1'b0;
        check("ovf_ptr", {23'd0, bus_if.wr_ptr}, 32'd256);
        rd1("ovf_rd0", 8'd0);
        rd1("ovf_rd255", 8'd255);
        bus_if.wr_rewind = 1'b1; tick(); bus_if.wr_rewind = 1'b0;
        check("rewind_full", {31'd0, bus_if.wr_full}, 32'd0);
        bus_if.wr_valid = 1'b1; bus_if.wr_data = 8'hAA; model[0] = 8'hAA; tick();
        check("aa_ptr", {23'd0, bus_if.wr_ptr}, 32'd1);
        bus_if.wr_rewind = 1'b1; bus_if.wr_data = 8'h77;
        check("rewind_pre_ready", {31'd0, bus_if.wr_ready}, 32'd1);
        tick();
        bus_if.wr_rewind = 1'b0; bus_if.wr_valid = 1'b0;
        check("rewind_prio_ptr", {23'd0, bus_if.wr_ptr}, 32'd0);
        bus_if.wr_valid = 1'b1; bus_if.wr_data = 8'hAA; tick();
        bus_if.wr_valid = 1'b0;
        rd1("rw_rd0", 8'd0);
        rd1("rw_rd1", 8'd1);

        // 4: read-before-write on the same address
        bus_if.wr_valid = 1'b1;
        for (int i = 1; i < 4; i++) begin
            bus_if.wr_data = 8'(i); tick();
        end
        check("ptr4", {23'd0, bus_if.wr_ptr}, 32'd4);
        bus_if.wr_data = 8'h5C;
        exp_q.push_back(8'h04);
        bus_if.rd_en = 1'b1; bus_if.rd_addr = 8'd4;
        tick();
        bus_if.rd_en = 1'b0; bus_if.wr_valid = 1'b0;
        model[4] = 8'h5C;
        check("rbw_old", {24'd0, bus_if.rd_data}, 32'h04);
        rd1("rbw_new", 8'd4);
        drain();

        // 5: clear request with reads held, then reset mid-sweep
        bus_if.clr_start = 1'b1; tick(); bus_if.clr_start = 1'b0;
        check("clr_busy", {31'd0, bus_if.busy}, 32'd1);
        check("clr_ptr", {23'd0, bus_if.wr_ptr}, 32'd0);
        bus_if.rd_en = 1'b1; bus_if.rd_addr = 8'd4;
        count_busy("sweep1");
        bus_if.rd_en = 1'b0;
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
        rd1("clr_rd4", 8'd4);
        rd1("clr_rd200", 8'd200);
        bus_if.wr_valid = 1'b1; bus_if.wr_data = 8'h99; tick(); bus_if.wr_valid = 1'b0;
        bus_if.clr_start = 1'b1; tick(); bus_if.clr_start = 1'b0;
        repeat (100) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        count_busy("sweep2");
        rd1("rst_rd0", 8'd0);
        drain();

        // 6: sequential read pointer (or plain addressed reads without it)
`ifdef RD_SEQ_EN
        exp_q.push_back(8'h00);
        bus_if.rd_en = 1'b1; bus_if.rd_seq = 1'b1; bus_if.rd_addr = 8'd7;
        tick();
        bus_if.rd_en = 1'b0; bus_if.rd_seq = 1'b0;
        check("seq_empty_valid", {31'd0, bus_if.rd_valid}, 32'd1);
        check("seq_empty_data", {24'd0, bus_if.rd_data}, 32'd0);
`endif
        bus_if.wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_if.wr_data = 8'hA0 + 8'(i);
            model[i] = 8'hA0 + 8'(i);
            tick();
        end
        bus_if.wr_valid = 1'b0;
        seq_addr[0] = 8'd2; seq_addr[1] = 8'd1; seq_addr[2] = 8'd0;
        seq_addr[3] = 8'd2; seq_addr[4] = 8'd1;
`ifdef RD_SEQ_EN
        seq_exp[0] = 8'hA0; seq_exp[1] = 8'hA1; seq_exp[2] = 8'hA2;
        seq_exp[3] = 8'hA0; seq_exp[4] = 8'hA1;
`else
        for (int i = 0; i < 5; i++) seq_exp[i] = model[seq_addr[i]];
`endif
        bus_if.rd_en = 1'b1; bus_if.rd_seq = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus_if.rd_addr = seq_addr[i];
            exp_q.push_back(seq_exp[i]);
            tick();
            check("seq_valid", {31'd0, bus_if.rd_valid}, 32'd1);
            check("seq_data", {24'd0, bus_if.rd_data}, {24'd0, seq_exp[i]});
        end
        bus_if.rd_en = 1'b0; bus_if.rd_seq = 1'b0;
        tick();
        check("rd_valid_pulse_end", {31'd0, bus_if.rd_valid}, 32'd0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
